alu_reg_sequencer: RTL and testbench
====================================

# alu_reg_sequencer

Multi-cycle command sequencer for the ALU/register-file datapath. It accepts one register-to-register command at a time over a valid/ready handshake and drives the synchronous-read register file and the combinational ALU (add/sub/logic/NOT units). It optionally re-applies the operation up to 16 times, feeding the result back as operand A, then writes the result back to the register file and reports completion with status flags.

## Interface
- word_size, 32, datapath width
- addr_size, 5, register address width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted on the edge where cmd_valid && cmd_ready
- cmd_op  in  3  000 PASS A, 001 ADD, 010 SUB (A−B), 011 AND, 100 OR, 101 XOR, 110 NOT (~B), 111 illegal
- cmd_ra / cmd_rb / cmd_rd  in  addr_size  source A, source B, destination
- cmd_count  in  4  extra iterations (0 = single op)
- rf_ra_addr / rf_rb_addr  out  addr_size  register read addresses
- rf_ra_data / rf_rb_data  in  word_size  read data, valid one cycle after address
- alu_op  out  3  latched opcode
- alu_a / alu_b  out  word_size  ALU operands
- alu_result  in  word_size  combinational ALU output, same cycle
- rf_we  out  1  write strobe
- rf_wr_addr  out  addr_size  write address
- rf_wr_data  out  word_size  write data
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; illegal opcode
- result  out  word_size  final result, held until next done
- zero / neg  out  1  result==0 / result[word_size-1], held with result
- busy  out  1  state != IDLE

## Operation
- States: IDLE, READ, EXEC, WRITE, ERR.
- IDLE: cmd_ready=1 (gated by !rst). On accept, latch op/ra/rb/rd/count, load iter=count. Go to ERR if op==111, else to READ.
- READ: drive rf_ra_addr/rf_rb_addr from the latched values. Go to EXEC.
- Addresses are held stable from READ through the last EXEC cycle. Register-file outputs are therefore valid and stable in every EXEC cycle.
- EXEC:
  - alu_op = latched op; alu_b = rf_rb_data.
  - alu_a = rf_ra_data on the first EXEC cycle, res_q on later cycles.
  - Register res_q <= alu_result on every EXEC cycle.
  - If iter==0, go to WRITE; else decrement iter and stay in EXEC.
- WRITE: rf_we=1, rf_wr_addr=rd, rf_wr_data=res_q, done=1, err=0. Update result/zero/neg from res_q. Go to IDLE.
- ERR: done=1, err=1, no register read or write; result/zero/neg unchanged. Go to IDLE.
- Arithmetic wraps modulo 2^word_size; no carry/overflow is reported.
- NOT ignores operand A; PASS ignores operand B. Both still iterate per count.
- rd may equal ra or rb. Reads complete before WRITE, so the old value is used.

## Timing
- Accepting edge = edge 0. READ occupies cycle 1; EXEC occupies cycles 2..count+2; WRITE occupies cycle count+3.
- done latency: count+3 cycles after accept. Illegal opcode: done in cycle 1.
- cmd_ready returns high in the cycle after WRITE/ERR. Back-to-back throughput is one command per count+4 cycles.
- rf_we and done are high for exactly one cycle per command.
- Reset:
  - All state registers go to IDLE and res_q, iter, result, zero, neg, err clear to 0.
  - cmd_ready, rf_we and done are forced low in any cycle where rst=1, including a WRITE-state cycle. An interrupted command performs no write.
  - cmd_valid during rst is ignored.
- Outputs when idle: rf_*_addr, alu_* and rf_wr_* are 0.

## Structure
- Shared include alu_reg_defs.vh: opcode localparams (OP_PASS..OP_NOT, OP_ILLEGAL) and the state encoding. The ALU decoder reuses the same opcode constants.
- One natural sub-module: iter_down_counter (4-bit loadable down-counter with zero flag). The FSM and operand muxing stay in this block.

## Test plan
- Reset, r1=5, r2=3. ADD ra=1 rb=2 rd=4 count=0 -> rf_we pulse in cycle 3 with addr 4, data 8; done=1, zero=0, neg=0.
- SUB ra=1 rb=2 (5−3), then SUB ra=2 rb=1 -> results 2 then 0xFFFFFFFE with neg=1. Second cmd_ready rises cycle 4 after first accept.
- NOT rb=0 (r0=0) rd=7 -> 0xFFFFFFFF written to r7. XOR ra=1 rb=1 -> 0, zero=1.
- ADD ra=1 rb=2 count=3 -> alu_a sequence 5, 8, 11, 14; result 17 written in cycle 6; busy high cycles 1–6.
- cmd_op=111 -> done=1, err=1 in cycle 1; rf_we never asserted; result unchanged from the prior command.
- Assert rst for one cycle during the WRITE cycle of an ADD -> no rf_we, done stays low, state IDLE, cmd_ready high the cycle after rst drops.

Source files
------------

// File: rtl/alu_reg_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_reg_sequencer_pkg
//   Shared constants for the ALU/register-file command sequencer: datapath
//   widths, opcode encodings (also used by the ALU decoder), iteration counter
//   width, and the FSM state encoding.
// -----------------------------------------------------------------------------
package alu_reg_sequencer_pkg;

   localparam int WORD_SIZE = 32;
   localparam int ADDR_SIZE = 5;
   localparam int ITER_W    = 4;

   // Opcodes
   localparam logic [2:0] OP_PASS    = 3'b000;
   localparam logic [2:0] OP_ADD     = 3'b001;
   localparam logic [2:0] OP_SUB     = 3'b010;
   localparam logic [2:0] OP_AND     = 3'b011;
   localparam logic [2:0] OP_OR      = 3'b100;
   localparam logic [2:0] OP_XOR     = 3'b101;
   localparam logic [2:0] OP_NOT     = 3'b110;
   localparam logic [2:0] OP_ILLEGAL = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_EXEC  = 3'd2,
      ST_WRITE = 3'd3,
      ST_ERR   = 3'd4
   } state_e;

endpackage

// File: rtl/alu_reg_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_reg_sequencer_if
//   Bundles the command handshake, register-file ports, ALU ports and status
//   outputs of the sequencer.
//   slave  : the sequencer side (takes commands, drives RF/ALU/status)
//   master : the environment side (issues commands, supplies RF/ALU data)
// -----------------------------------------------------------------------------
interface alu_reg_sequencer_if;
   import alu_reg_sequencer_pkg::*;

   // command handshake
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [2:0]           cmd_op;
   logic [ADDR_SIZE-1:0] cmd_ra;
   logic [ADDR_SIZE-1:0] cmd_rb;
   logic [ADDR_SIZE-1:0] cmd_rd;
   logic [ITER_W-1:0]    cmd_count;
   // register file
   logic [ADDR_SIZE-1:0] rf_ra_addr;
   logic [ADDR_SIZE-1:0] rf_rb_addr;
   logic [WORD_SIZE-1:0] rf_ra_data;
   logic [WORD_SIZE-1:0] rf_rb_data;
   logic                 rf_we;
   logic [ADDR_SIZE-1:0] rf_wr_addr;
   logic [WORD_SIZE-1:0] rf_wr_data;
   // ALU
   logic [2:0]           alu_op;
   logic [WORD_SIZE-1:0] alu_a;
   logic [WORD_SIZE-1:0] alu_b;
   logic [WORD_SIZE-1:0] alu_result;
   // status
   logic                 done;
   logic                 err;
   logic [WORD_SIZE-1:0] result;
   logic                 zero;
   logic                 neg;
   logic                 busy;

   modport slave (
      input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_count,
      input  rf_ra_data, rf_rb_data, alu_result,
      output cmd_ready, rf_ra_addr, rf_rb_addr, rf_we, rf_wr_addr, rf_wr_data,
      output alu_op, alu_a, alu_b, done, err, result, zero, neg, busy
   );

   modport master (
      output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_count,
      output rf_ra_data, rf_rb_data, alu_result,
      input  cmd_ready, rf_ra_addr, rf_rb_addr, rf_we, rf_wr_addr, rf_wr_data,
      input  alu_op, alu_a, alu_b, done, err, result, zero, neg, busy
   );

endinterface

// File: rtl/alu_reg_sequencer_iter_down_counter.sv
// -----------------------------------------------------------------------------
// iter_down_counter
//   Loadable down-counter with zero flag. Counts the extra ALU iterations.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_load/i_val : load a new count (priority over decrement)
//   i_dec        : decrement; saturates at zero
//   o_count      : current count
//   o_zero       : o_count == 0
// -----------------------------------------------------------------------------
module iter_down_counter
   import alu_reg_sequencer_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load,
   input  logic [ITER_W-1:0] i_val,
   input  logic              i_dec,
   output logic [ITER_W-1:0] o_count,
   output logic              o_zero
);

   logic [ITER_W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_count <= '0;
      else if (i_load)
         r_count <= i_val;
      else if (i_dec && (r_count != '0))
         r_count <= r_count - 1'b1;
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule

// File: rtl/alu_reg_sequencer.sv
// -----------------------------------------------------------------------------
// alu_reg_sequencer
//   Multi-cycle command sequencer for the register-file/ALU datapath. Accepts
//   one command, reads two registers (synchronous read), runs the ALU
//   1+count times feeding the result back as operand A, writes the result to
//   rd and pulses done with status flags. Opcode 111 skips straight to an
//   error completion.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : command / register-file / ALU / status bundle (slave side)
// -----------------------------------------------------------------------------
module alu_reg_sequencer
   import alu_reg_sequencer_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   alu_reg_sequencer_if.slave bus
);

   state_e               r_state, w_next;
   logic [2:0]           r_op;
   logic [ADDR_SIZE-1:0] r_ra, r_rb, r_rd;
   logic [WORD_SIZE-1:0] r_res;
   logic [WORD_SIZE-1:0] r_result;
   logic                 r_zero, r_neg;
   logic                 r_first;      // current EXEC cycle is the first one
   logic                 w_accept;
   logic                 w_iter_zero;
   logic [ITER_W-1:0]    w_iter;

   assign w_accept = (r_state == ST_IDLE) && bus.cmd_valid && !i_rst;

   iter_down_counter u_iter (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_accept),
      .i_val   (bus.cmd_count),
      .i_dec   (r_state == ST_EXEC),
      .o_count (w_iter),
      .o_zero  (w_iter_zero)
   );

   // state and datapath registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_op     <= '0;
         r_ra     <= '0;
         r_rb     <= '0;
         r_rd     <= '0;
         r_res    <= '0;
         r_result <= '0;
         r_zero   <= 1'b0;
         r_neg    <= 1'b0;
         r_first  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_first <= (r_state == ST_READ);
         if (w_accept) begin
            r_op <= bus.cmd_op;
            r_ra <= bus.cmd_ra;
            r_rb <= bus.cmd_rb;
            r_rd <= bus.cmd_rd;
         end
         if (r_state == ST_EXEC)
            r_res <= bus.alu_result;
         if (r_state == ST_WRITE) begin
            r_result <= r_res;
            r_zero   <= (r_res == '0);
            r_neg    <= r_res[WORD_SIZE-1];
         end
      end
   end

   // next state and datapath outputs
   always_comb begin
      w_next         = r_state;
      bus.cmd_ready  = 1'b0;
      bus.rf_ra_addr = '0;
      bus.rf_rb_addr = '0;
      bus.alu_op     = '0;
      bus.alu_a      = '0;
      bus.alu_b      = '0;
      bus.rf_we      = 1'b0;
      bus.rf_wr_addr = '0;
      bus.rf_wr_data = '0;
      bus.done       = 1'b0;
      bus.err        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            bus.cmd_ready = 1'b1;
            if (bus.cmd_valid)
               w_next = (bus.cmd_op == OP_ILLEGAL) ? ST_ERR : ST_READ;
         end
         ST_READ: begin
            bus.rf_ra_addr = r_ra;
            bus.rf_rb_addr = r_rb;
            w_next         = ST_EXEC;
         end
         ST_EXEC: begin
            // addresses stay put so RF data remains valid for every iteration
            bus.rf_ra_addr = r_ra;
            bus.rf_rb_addr = r_rb;
            bus.alu_op     = r_op;
            bus.alu_a      = r_first ? bus.rf_ra_data : r_res;
            bus.alu_b      = bus.rf_rb_data;
            if (w_iter_zero)
               w_next = ST_WRITE;
         end
         ST_WRITE: begin
            bus.rf_we      = 1'b1;
            bus.rf_wr_addr = r_rd;
            bus.rf_wr_data = r_res;
            bus.done       = 1'b1;
            w_next         = ST_IDLE;
         end
         ST_ERR: begin
            bus.done = 1'b1;
            bus.err  = 1'b1;
            w_next   = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase

      // reset kills any handshake or write in the same cycle
      if (i_rst) begin
         bus.cmd_ready = 1'b0;
         bus.rf_we     = 1'b0;
         bus.done      = 1'b0;
         bus.err       = 1'b0;
      end
   end

   assign bus.result = r_result;
   assign bus.zero   = r_zero;
   assign bus.neg    = r_neg;
   assign bus.busy   = (r_state != ST_IDLE);

   // keep the counter value visible for debug without an unused warning
   logic w_unused;
   assign w_unused = ^w_iter;

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_reg_sequencer
//   Directed bench: behavioural register file (sync read) and ALU around the
//   sequencer, hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_alu_reg_sequencer;
   import alu_reg_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_reg_sequencer_if bus ();

   alu_reg_sequencer dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   // environment: register file with synchronous read
   logic [31:0] rf [32];
   always @(posedge clk) begin
      bus.rf_ra_data <= rf[bus.rf_ra_addr];
      bus.rf_rb_data <= rf[bus.rf_rb_addr];
      if (bus.rf_we) rf[bus.rf_wr_addr] <= bus.rf_wr_data;
   end

   // environment: combinational ALU
   always_comb begin
      bus.alu_result = 32'h0;
      case (bus.alu_op)
         3'b000: bus.alu_result = bus.alu_a;
         3'b001: bus.alu_result = bus.alu_a + bus.alu_b;
         3'b010: bus.alu_result = bus.alu_a - bus.alu_b;
         3'b011: bus.alu_result = bus.alu_a & bus.alu_b;
         3'b100: bus.alu_result = bus.alu_a | bus.alu_b;
         3'b101: bus.alu_result = bus.alu_a ^ bus.alu_b;
         3'b110: bus.alu_result = ~bus.alu_b;
         default: bus.alu_result = 32'h0;
      endcase
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   // per-command observations (cycle numbers relative to accept edge 0)
   int          done_cyc, we_cyc, we_cnt, done_cnt, busy_cnt, ready_cyc;
   logic [31:0] we_addr, we_data;
   logic        err_at_done;
   logic [31:0] a_seq [16];

   task automatic run_cmd(input logic [2:0] op, input logic [4:0] ra, input logic [4:0] rb,
                          input logic [4:0] rd, input logic [3:0] cnt);
      done_cyc = 0; we_cyc = 0; we_cnt = 0; done_cnt = 0; busy_cnt = 0; ready_cyc = 0;
      we_addr = 0; we_data = 0; err_at_done = 0;
      for (int i = 0; i < 16; i++) a_seq[i] = 32'h0;
      @(negedge clk);
      chk("ready_before_issue", {31'b0, bus.cmd_ready}, 32'd1);
      bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_ra = ra; bus.cmd_rb = rb;
      bus.cmd_rd = rd; bus.cmd_count = cnt;
      @(posedge clk);                       // edge 0
      for (int c = 1; c <= int'(cnt) + 8; c++) begin
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         if (c < 16) a_seq[c] = bus.alu_a;
         if (bus.busy) busy_cnt++;
         if (bus.rf_we) begin we_cnt++; we_cyc = c; we_addr = 32'(bus.rf_wr_addr); we_data = bus.rf_wr_data; end
         if (bus.done) begin done_cnt++; done_cyc = c; err_at_done = bus.err; end
         if (bus.cmd_ready && ready_cyc == 0) ready_cyc = c;
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      rf[1] = 32'd5;
      rf[2] = 32'd3;
      bus.cmd_valid = 1'b1;   // must be ignored during reset
      bus.cmd_op = 3'b001; bus.cmd_ra = 5'd1; bus.cmd_rb = 5'd2;
      bus.cmd_rd = 5'd4; bus.cmd_count = 4'd0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_ready",  {31'b0, bus.cmd_ready}, 32'd0);
      chk("rst_busy",   {31'b0, bus.busy},      32'd0);
      chk("rst_done",   {31'b0, bus.done},      32'd0);
      chk("rst_we",     {31'b0, bus.rf_we},     32'd0);
      chk("rst_result", bus.result,             32'd0);
      rst = 1'b0; bus.cmd_valid = 1'b0;
      @(negedge clk);
      chk("idle_ready",  {31'b0, bus.cmd_ready}, 32'd1);
      chk("idle_busy",   {31'b0, bus.busy},      32'd0);
      chk("idle_ra_addr", 32'(bus.rf_ra_addr),   32'd0);
      chk("idle_alu_a",  bus.alu_a,              32'd0);

      // ADD r1+r2 -> r4
      run_cmd(3'b001, 5'd1, 5'd2, 5'd4, 4'd0);
      chk("add_we_cyc",   we_cyc,   3);
      chk("add_we_cnt",   we_cnt,   1);
      chk("add_we_addr",  we_addr,  32'd4);
      chk("add_we_data",  we_data,  32'd8);
      chk("add_done_cyc", done_cyc, 3);
      chk("add_done_cnt", done_cnt, 1);
      chk("add_err",      {31'b0, err_at_done}, 32'd0);
      chk("add_result",   bus.result, 32'd8);
      chk("add_zero",     {31'b0, bus.zero}, 32'd0);
      chk("add_neg",      {31'b0, bus.neg},  32'd0);
      chk("add_ready_cyc", ready_cyc, 4);
      chk("add_rf4",      rf[4], 32'd8);

      // SUB 5-3 then 3-5
      run_cmd(3'b010, 5'd1, 5'd2, 5'd5, 4'd0);
      chk("sub1_result", bus.result, 32'd2);
      chk("sub1_ready_cyc", ready_cyc, 4);
      run_cmd(3'b010, 5'd2, 5'd1, 5'd6, 4'd0);
      chk("sub2_result", bus.result, 32'hFFFF_FFFE);
      chk("sub2_neg",    {31'b0, bus.neg},  32'd1);
      chk("sub2_zero",   {31'b0, bus.zero}, 32'd0);

      // NOT r0 -> r7, XOR r1^r1 -> r8
      run_cmd(3'b110, 5'd1, 5'd0, 5'd7, 4'd0);
      chk("not_result", bus.result, 32'hFFFF_FFFF);
      chk("not_rf7",    rf[7],      32'hFFFF_FFFF);
      run_cmd(3'b101, 5'd1, 5'd1, 5'd8, 4'd0);
      chk("xor_result", bus.result, 32'd0);
      chk("xor_zero",   {31'b0, bus.zero}, 32'd1);
      chk("xor_neg",    {31'b0, bus.neg},  32'd0);

      // iterated ADD: 5+3+3+3+3
      run_cmd(3'b001, 5'd1, 5'd2, 5'd9, 4'd3);
      chk("iter_a2", a_seq[2], 32'd5);
      chk("iter_a3", a_seq[3], 32'd8);
      chk("iter_a4", a_seq[4], 32'd11);
      chk("iter_a5", a_seq[5], 32'd14);
      chk("iter_we_cyc",  we_cyc,   6);
      chk("iter_we_data", we_data,  32'd17);
      chk("iter_we_cnt",  we_cnt,   1);
      chk("iter_busy",    busy_cnt, 6);
      chk("iter_rf9",     rf[9],    32'd17);

      // illegal opcode
      run_cmd(3'b111, 5'd1, 5'd2, 5'd11, 4'd0);
      chk("ill_done_cyc", done_cyc, 1);
      chk("ill_err",      {31'b0, err_at_done}, 32'd1);
      chk("ill_we_cnt",   we_cnt, 0);
      chk("ill_result",   bus.result, 32'd17);
      chk("ill_ready_cyc", ready_cyc, 2);
      chk("ill_rf11",     rf[11], 32'd0);

      // reset during the WRITE cycle of an ADD -> r10
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_op = 3'b001; bus.cmd_ra = 5'd1; bus.cmd_rb = 5'd2;
      bus.cmd_rd = 5'd10; bus.cmd_count = 4'd0;
      @(posedge clk);                       // edge 0
      #1 bus.cmd_valid = 1'b0;
      @(posedge clk);                       // edge 1 -> EXEC
      @(posedge clk);                       // edge 2 -> WRITE
      #1 rst = 1'b1;
      @(negedge clk);                       // cycle 3
      chk("rstw_we",    {31'b0, bus.rf_we},     32'd0);
      chk("rstw_done",  {31'b0, bus.done},      32'd0);
      chk("rstw_ready", {31'b0, bus.cmd_ready}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);                       // cycle 4
      chk("rstw_busy",   {31'b0, bus.busy},      32'd0);
      chk("rstw_ready2", {31'b0, bus.cmd_ready}, 32'd1);
      chk("rstw_we2",    {31'b0, bus.rf_we},     32'd0);
      chk("rstw_rf10",   rf[10],                 32'd0);
      chk("rstw_result", bus.result,             32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   // global watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
